// File: rtl/exception_ctrl.sv
// Commit-stage exception/ERET sequencer: latch context, flush, write CP0, redirect fetch.
// Ports: clk/resetn, commit inputs (excepttype, pc, delay slot, badvaddr, epc), CP0 strobes/data, redirect handshake.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_VEC = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        commit_valid,
    input  logic [31:0] excepttype,
    input  logic [31:0] commit_pc,
    input  logic        in_delayslot,
    input  logic [31:0] badvaddr_in,
    input  logic [31:0] cp0_epc,
    output logic        busy,
    output logic        flush,
    output logic        cp0_exc_we,
    output logic        cp0_eret_we,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_epc_out,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] tgt_q, tgt_d;
    logic        legal;
    logic        accept;
    logic        is_eret;

    always_comb begin
        legal = 1'b0;
        case (excepttype)
            32'h1, 32'h4, 32'h5, 32'h8,
            32'h9, 32'hA, 32'hC, 32'hE: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
    end

    assign accept = (state_q == IDLE) && commit_valid && legal;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        pc_d    = pc_q;
        ds_d    = ds_q;
        badv_d  = badv_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FLUSH;
                    type_d  = excepttype[3:0];
                    pc_d    = commit_pc;
                    ds_d    = in_delayslot;
                    badv_d  = badvaddr_in;
                    // ERET returns to EPC as sampled at commit.
                    tgt_d   = (excepttype[3:0] == 4'hE) ? cp0_epc : HANDLER_VEC;
                end
            end
            FLUSH:    state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            type_q  <= 4'h0;
            pc_q    <= 32'h0;
            ds_q    <= 1'b0;
            badv_q  <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pc_q    <= pc_d;
            ds_q    <= ds_d;
            badv_q  <= badv_d;
            tgt_q   <= tgt_d;
        end
    end

    // Strobes decode straight from state so reset drops them at once.
    assign is_eret        = (type_q == 4'hE);
    assign busy           = (state_q != IDLE);
    assign flush          = (state_q == FLUSH);
    assign cp0_exc_we     = flush && !is_eret;
    assign cp0_eret_we    = flush && is_eret;
    assign cp0_badv_we    = flush && ((type_q == 4'h4) || (type_q == 4'h5));
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = tgt_q;

    // Delay-slot faults report the branch; wraps modulo 2^32.
    assign cp0_epc_out  = ds_q ? (pc_q - 32'd4) : pc_q;
    assign cp0_bd       = ds_q;
    // Type codes equal ExcCode except Int (1 -> 0).
    assign cp0_exccode  = (type_q == 4'h1) ? 5'd0 : {1'b0, type_q};
    assign cp0_badvaddr = badv_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: randomized and directed events
// against a cycle-window reference model.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] excepttype = '0;
    logic [31:0] commit_pc = '0;
    logic        in_delayslot = 1'b0;
    logic [31:0] badvaddr_in = '0;
    logic [31:0] cp0_epc = '0;
    logic        busy, flush, cp0_exc_we, cp0_eret_we, cp0_badv_we;
    logic [31:0] cp0_epc_out, cp0_badvaddr, redirect_pc;
    logic [4:0]  cp0_exccode;
    logic        cp0_bd, redirect_valid;
    logic        redirect_ready = 1'b0;

    exception_ctrl #(.HANDLER_VEC(VEC)) dut (
        .clk(clk), .resetn(resetn), .commit_valid(commit_valid),
        .excepttype(excepttype), .commit_pc(commit_pc),
        .in_delayslot(in_delayslot), .badvaddr_in(badvaddr_in),
        .cp0_epc(cp0_epc), .busy(busy), .flush(flush),
        .cp0_exc_we(cp0_exc_we), .cp0_eret_we(cp0_eret_we),
        .cp0_badv_we(cp0_badv_we), .cp0_epc_out(cp0_epc_out),
        .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
        .cp0_badvaddr(cp0_badvaddr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic        eret;
        logic        bwe;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] badv;
    } fexp_t;

    fexp_t       flushq[$];
    logic [31:0] redq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int b_lo = 1, b_hi = 0;
    int r_lo = 1, r_hi = 0;
    int force_nlow = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [31:0] t);
        return t inside {32'h1, 32'h4, 32'h5, 32'h8,
                         32'h9, 32'hA, 32'hC, 32'hE};
    endfunction

    function automatic logic [4:0] code_of(input logic [31:0] t);
        case (t)
            32'h1:   return 5'd0;
            32'h4:   return 5'd4;
            32'h5:   return 5'd5;
            32'h8:   return 5'd8;
            32'h9:   return 5'd9;
            32'hA:   return 5'd10;
            32'hC:   return 5'd12;
            default: return 5'd0;
        endcase
    endfunction

    task automatic step(input logic v, input logic [31:0] t,
                        input logic [31:0] pc, input logic ds,
                        input logic [31:0] bv, input logic [31:0] ep);
        fexp_t e;
        int nl;
        @(negedge clk);
        cyc++;
        chk("busy", busy, (cyc >= b_lo && cyc <= b_hi));
        chk("flush", flush, (cyc == b_lo && b_lo <= b_hi));
        chk("redirect_valid", redirect_valid, (cyc > b_lo && cyc <= b_hi));
        if (cyc >= r_lo && cyc <= r_hi) redirect_ready = 1'b0;
        else if (cyc == b_hi)           redirect_ready = 1'b1;
        else                            redirect_ready = 1'($urandom);
        commit_valid = v;
        excepttype   = t;
        commit_pc    = pc;
        in_delayslot = ds;
        badvaddr_in  = bv;
        cp0_epc      = ep;
        if (cyc > b_hi && v && legal(t)) begin
            nl   = (force_nlow >= 0) ? force_nlow : int'($urandom_range(0, 3));
            b_lo = cyc + 1;
            b_hi = cyc + 2 + nl;
            r_lo = cyc + 2;
            r_hi = cyc + 1 + nl;
            e.eret = (t == 32'hE);
            e.exc  = !e.eret;
            e.bwe  = (t == 32'h4 || t == 32'h5);
            e.epc  = ds ? pc - 32'd4 : pc;
            e.code = code_of(t);
            e.bd   = ds;
            e.badv = bv;
            flushq.push_back(e);
            redq.push_back(e.eret ? ep : VEC);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        commit_valid   = 1'b0;
        redirect_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_epc_out", cp0_epc_out, 32'h0);
        flushq.delete();
        redq.delete();
        b_lo = 1; b_hi = 0; r_lo = 1; r_hi = 0;
        @(negedge clk);
        cyc++;
        resetn = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or handshake.
    initial begin
        fexp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resetn) begin
                if (!flush && (cp0_exc_we || cp0_eret_we || cp0_badv_we))
                    chk("strobe_outside_flush", 1'b1, 1'b0);
                if (flush) begin
                    if (flushq.size() == 0) begin
                        chk("unexpected_flush", 1'b1, 1'b0);
                    end else begin
                        e = flushq.pop_front();
                        chk("cp0_exc_we", cp0_exc_we, e.exc);
                        chk("cp0_eret_we", cp0_eret_we, e.eret);
                        chk("cp0_badv_we", cp0_badv_we, e.bwe);
                        if (e.exc) begin
                            chk("cp0_epc_out", cp0_epc_out, e.epc);
                            chk("cp0_exccode", cp0_exccode, e.code);
                            chk("cp0_bd", cp0_bd, e.bd);
                        end
                        if (e.bwe) chk("cp0_badvaddr", cp0_badvaddr, e.badv);
                    end
                end
                if (redirect_valid) begin
                    if (redq.size() == 0) begin
                        chk("unexpected_redirect", 1'b1, 1'b0);
                    end else begin
                        chk("redirect_pc", redirect_pc, redq[0]);
                        if (redirect_ready) void'(redq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] tlist [12];
        tlist = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA,
                  32'hC, 32'hE, 32'h0, 32'h7, 32'h2, 32'h108};
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_flush", flush, 1'b0);
        chk("reset_exc_we", cp0_exc_we, 1'b0);
        chk("reset_redirect_valid", redirect_valid, 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_exccode", cp0_exccode, 5'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        force_nlow = 0;
        step(1'b1, 32'h8, 32'h8000_0100, 1'b0, 32'h0, 32'h0);
        idle(3);
        step(1'b1, 32'h4, 32'h8000_0204, 1'b1, 32'h8000_0003, 32'h0);
        idle(3);
        force_nlow = 3;
        step(1'b1, 32'hE, 32'h8000_0400, 1'b0, 32'h0, 32'h8000_1000);
        idle(6);
        force_nlow = -1;
        step(1'b1, 32'h1, 32'h0, 1'b1, 32'h0, 32'h0);
        step(1'b1, 32'hC, 32'h8000_0500, 1'b0, 32'h0, 32'h0);
        idle(5);

        force_nlow = 0;
        step(1'b1, 32'h8, 32'h8000_0600, 1'b0, 32'h0, 32'h0);
        idle(1);
        step(1'b1, 32'h9, 32'h8000_0700, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h9, 32'h8000_0800, 1'b0, 32'h0, 32'h0);
        idle(4);

        force_nlow = 3;
        step(1'b1, 32'hE, 32'h8000_0900, 1'b0, 32'h0, 32'h8000_2000);
        idle(2);
        do_reset();
        step(1'b1, 32'h0, 32'h8000_0A00, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h7, 32'h8000_0B00, 1'b0, 32'h0, 32'h0);
        idle(2);

        force_nlow = -1;
        step(1'b0, 32'h5, 32'h8000_0C00, 1'b0, 32'h1234_5679, 32'h0);
        step(1'b1, 32'h5, 32'h8000_0C00, 1'b0, 32'h1234_5679, 32'h0);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 tlist[$urandom_range(0, 11)],
                 {$urandom, 2'b00} & 32'hFFFF_FFFC,
                 1'($urandom),
                 $urandom,
                 $urandom);
        end
        idle(8);
        chk("flushq_drained", flushq.size(), 0);
        chk("redq_drained", redq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequencer that turns a committed exception/ERET decision into the ordered side effects the core needs. It sits after the exception-type encoder at the commit stage: it latches the offending instruction's context, issues the pipeline flush, writes the CP0 exception fields (EPC, Cause.ExcCode, Cause.BD, Status.EXL, BadVAddr), then redirects fetch to the handler vector or to EPC through a valid/ready handshake. While busy it stalls commit, so each event is handled exactly once.

## Interface
- HANDLER_VEC, 32'hBFC0_0380, exception entry PC
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- commit_valid  in  1  commit-stage slot holds a real instruction this cycle
- excepttype  in  32  encoded type: 0 none, 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, A RI, C Ov, E ERET
- commit_pc  in  32  PC of the committing instruction
- in_delayslot  in  1  committing instruction is in a branch delay slot
- badvaddr_in  in  32  faulting address (valid for types 4/5)
- cp0_epc  in  32  current CP0.EPC (ERET target)
- busy  out  1  controller active; commit must stall
- flush  out  1  one-cycle pipeline flush pulse
- cp0_exc_we  out  1  one-cycle strobe: write EPC, ExcCode, BD, set Status.EXL
- cp0_eret_we  out  1  one-cycle strobe: clear Status.EXL
- cp0_badv_we  out  1  one-cycle strobe: write BadVAddr
- cp0_epc_out  out  32  EPC value to write
- cp0_exccode  out  5  Cause.ExcCode
- cp0_bd  out  1  Cause.BD
- cp0_badvaddr  out  32  BadVAddr value
- redirect_valid  out  1  new fetch PC offered
- redirect_pc  out  32  fetch target
- redirect_ready  in  1  fetch accepts redirect

## Operation
- States: IDLE, FLUSH, REDIRECT.
- IDLE: accept when commit_valid=1 and excepttype is one of the eight listed codes; other values (including 0) ignored. Latch type, commit_pc, in_delayslot, badvaddr_in, cp0_epc; go FLUSH.
- FLUSH (exactly one cycle): flush=1.
  - Exception (not E): cp0_exc_we=1; cp0_epc_out = in_delayslot ? commit_pc-4 (mod 2^32) : commit_pc; cp0_bd = in_delayslot; cp0_exccode = Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12. cp0_badv_we=1 only for AdEL/AdES, cp0_badvaddr = latched badvaddr. Target = HANDLER_VEC.
  - ERET (E): cp0_eret_we=1, no other CP0 strobe; target = latched cp0_epc.
  - Go REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target, both stable until redirect_valid && redirect_ready; that cycle is the last REDIRECT cycle, next state IDLE.
- busy=1 in FLUSH and REDIRECT; inputs ignored while busy (no queuing, no re-latch).
- Data outputs (cp0_*, redirect_pc) hold latched values outside their strobe cycles; checked only when qualified.

## Timing
- Reset (resetn=0, async): state IDLE; busy, flush, all *_we, redirect_valid = 0; cp0_epc_out, cp0_badvaddr, redirect_pc = 0; cp0_exccode=0, cp0_bd=0. Takes effect immediately mid-sequence; pending redirect is dropped.
- Accept at edge ending cycle T → FLUSH in T+1 (flush, CP0 strobes, busy=1) → REDIRECT from T+2.
- Ready already high in T+2 → handshake in T+2, IDLE/busy=0 in T+3; minimum 3 cycles from accept to next accept possible in T+3.
- Ready low N cycles → REDIRECT lasts N+1 cycles.
- Strobes never assert in IDLE or REDIRECT; flush and CP0 strobes coincide in one cycle.
- Back-to-back events: new event presented in the handshake cycle is ignored; presented at T+3 (IDLE) is accepted.

## Test plan
- Sys (8) at pc 0x8000_0100, not delay slot, ready=1 → T+1 flush=1, cp0_exc_we=1, epc 0x8000_0100, exccode 8, bd 0, badv_we 0; T+2 redirect_pc 0xBFC0_0380; busy low T+3.
- AdEL (4) in delay slot, pc 0x8000_0204, badvaddr 0x8000_0003 → epc 0x8000_0200, bd 1, exccode 4, badv_we 1, badvaddr 0x8000_0003.
- ERET (E), cp0_epc 0x8000_1000, ready low 3 cycles → cp0_eret_we=1 only, redirect_valid held 4 cycles at 0x8000_1000, then IDLE.
- Int (1) at pc 0x0 in delay slot → epc 0xFFFF_FFFC (wrap), exccode 0; Ov (C) while busy → ignored, no second flush.
- resetn low during REDIRECT → redirect_valid, busy drop asynchronously; after release excepttype 0 or 7 with commit_valid=1 → no activity.
- excepttype 5 with commit_valid=0 → ignored; then valid → exccode 5, badv_we 1.
